// File: rtl/image_loader.sv
// rtl/image_loader.sv - streams 32-bit pixel words into four byte-wide image RAM banks.
module image_loader #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] image_ram_addr,
  output logic [7:0]        data_image_0,
  output logic [7:0]        data_image_1,
  output logic [7:0]        data_image_2,
  output logic [7:0]        data_image_3,
  output logic              we_image,
  output logic              busy,
  output logic              done,
  output logic              drop_err,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W:0]   target;
  logic [ADDR_W:0]   count_next;
  logic              xfer;

  assign in_ready   = (state == LOAD);
  assign busy       = (state != IDLE);
  assign xfer       = in_valid & in_ready;
  assign count_next = words_written + ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      target         <= '0;
      image_ram_addr <= '0;
      data_image_0   <= '0;
      data_image_1   <= '0;
      data_image_2   <= '0;
      data_image_3   <= '0;
      we_image       <= 1'b0;
      done           <= 1'b0;
      drop_err       <= 1'b0;
      words_written  <= '0;
    end else begin
      we_image <= 1'b0;
      done     <= 1'b0;

      // Write lands one cycle after the handshake; addr/data hold otherwise.
      if (xfer) begin
        we_image       <= 1'b1;
        image_ram_addr <= words_written[ADDR_W-1:0];
        data_image_0   <= in_data[7:0];
        data_image_1   <= in_data[15:8];
        data_image_2   <= in_data[23:16];
        data_image_3   <= in_data[31:24];
        words_written  <= count_next;
      end

      case (state)
        IDLE: begin
          if (start) begin
            words_written <= '0;
            if (num_words == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              target   <= (num_words > DEPTH_W) ? DEPTH_W : num_words;
              drop_err <= 1'b0;
              state    <= LOAD;
            end
          end else if (in_valid) begin
            drop_err <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer && count_next == target) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          if (in_valid) drop_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_loader.sv
// tb/tb_image_loader.sv - table-driven and randomized checks of image_loader against a load-level model.
module tb_image_loader;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 16384;

  logic              clk = 1'b0;
  logic              reset, start, in_valid;
  logic [ADDR_W:0]   num_words;
  logic [31:0]       in_data;
  logic              in_ready, we_image, busy, done, drop_err;
  logic [ADDR_W-1:0] image_ram_addr;
  logic [7:0]        data_image_0, data_image_1, data_image_2, data_image_3;
  logic [ADDR_W:0]   words_written;

  image_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .image_ram_addr(image_ram_addr), .data_image_0(data_image_0),
    .data_image_1(data_image_1), .data_image_2(data_image_2),
    .data_image_3(data_image_3), .we_image(we_image), .busy(busy),
    .done(done), .drop_err(drop_err), .words_written(words_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    int n;
    int pct;
    int exp_w;
    bit fixed;
  } vec_t;

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  last_we_cyc = 0;
  wr_t wr_q[$];

  always @(posedge clk) cyc++;

  // Observed write stream and done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (we_image) begin
      wr_q.push_back('{image_ram_addr, {data_image_3, data_image_2, data_image_1, data_image_0}});
      last_we_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_load(input int n, input int pct, input int exp_w, input bit fixed,
                          input bit valid_at_start, input string name);
    logic [31:0] w[$];
    int i, k, start_cyc, bad;
    wr_q.delete();
    done_cnt = 0;
    for (int j = 0; j < exp_w; j++) begin
      if (fixed) w.push_back({8'(4*j+4), 8'(4*j+3), 8'(4*j+2), 8'(4*j+1)});
      else       w.push_back($urandom);
    end
    @(posedge clk); #1;
    start     = 1'b1;
    num_words = (ADDR_W + 1)'(n);
    in_valid  = valid_at_start;
    in_data   = 32'hDEAD_BEEF;
    start_cyc = cyc;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    i = 0;
    k = 0;
    while (i < exp_w && k < 40000) begin
      in_valid = (pct < 0) ? (k % 2 == 0) : (int'($urandom_range(1, 100)) <= pct);
      in_data  = w[i];
      @(negedge clk);
      if (in_valid && in_ready) i++;
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    k = 0;
    while (done_cnt == 0 && k < 6) begin
      @(posedge clk); #1;
      k++;
    end
    @(negedge clk);
    check({name, "_accepted"}, i, exp_w);
    check({name, "_nwrites"}, wr_q.size(), exp_w);
    bad = 0;
    foreach (wr_q[j]) begin
      if (j >= w.size() || wr_q[j].addr !== ADDR_W'(j) || wr_q[j].data !== w[j]) bad++;
    end
    check({name, "_content_errs"}, bad, 0);
    check({name, "_done_cnt"}, done_cnt, 1);
    if (exp_w > 0) check({name, "_done_with_last_write"}, done_cyc, last_we_cyc);
    else           check({name, "_done_within_2"}, (done_cyc - start_cyc) <= 2, 1);
    check({name, "_words_written"}, words_written, exp_w);
    check({name, "_idle_in_ready"}, in_ready, 0);
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_drop_err"}, drop_err, 0);
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{4, 100, 4, 1'b1};
    tbl[1] = '{3, -1, 3, 1'b0};
    tbl[2] = '{0, 100, 0, 1'b0};
    tbl[3] = '{1, 100, 1, 1'b0};
    tbl[4] = '{20000, 100, DEPTH, 1'b0};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; num_words = '0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {in_ready, we_image, busy, done, drop_err}, 5'b0);
    check("rst_addr_data", {image_ram_addr, data_image_0, data_image_1, data_image_2, data_image_3}, '0);
    check("rst_words_written", words_written, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int t = 0; t < 5; t++) begin
      run_load(tbl[t].n, tbl[t].pct, tbl[t].exp_w, tbl[t].fixed, 1'b0, $sformatf("vec%0d", t));
      if (tbl[t].fixed) check("vec_addr0_lanes", (wr_q.size() > 0) ? wr_q[0].data : 32'hX, 32'h0403_0201);
    end

    // Stray word in IDLE sets drop_err; a start presented with a word clears it.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = $urandom; wr_q.delete();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("drop_set", drop_err, 1);
    check("drop_no_write", wr_q.size(), 0);
    run_load(2, 100, 2, 1'b0, 1'b1, "drop_start_clash");
    @(posedge clk); #1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("drop_set2", drop_err, 1);
    run_load(3, 70, 3, 1'b0, 1'b0, "drop_clear");

    // Reset after two of five words.
    wr_q.delete();
    @(posedge clk); #1;
    start = 1'b1; num_words = 5;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = $urandom;
    @(posedge clk); #1;
    in_data = $urandom;
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_we", we_image, 0);
    check("midrst_words_written", words_written, 0);
    check("midrst_busy", busy, 0);
    check("midrst_writes_before", wr_q.size(), 2);
    run_load(2, 100, 2, 1'b0, 1'b0, "after_rst");

    for (int r = 0; r < 8; r++) begin
      int n, pct;
      n   = $urandom_range(1, 40);
      pct = $urandom_range(20, 100);
      run_load(n, pct, (n > DEPTH) ? DEPTH : n, 1'b0, 1'b0, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    tests++;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/image_loader.md
Name: image_loader

Overview:
- Upstream feeder for the on-chip memory stage.
- Accepts 32-bit pixel words from the HPS-side streaming/bridge interface via a valid/ready handshake.
- Splits each word into four bytes, one per image RAM bank, and drives the bank write address, the four data lanes and a common write enable.
- Frames one image load per start command, counts words, and reports completion and protocol errors.

Parameters:
- ADDR_W, 14, width of the image RAM word address (one address indexes all four banks).
- DEPTH, 16384, maximum words per load; must be ≤ 2**ADDR_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE.
- num_words  in  ADDR_W+1  words to load; latched on an accepted start.
- in_valid  in  1  upstream word valid.
- in_data  in  32  pixel word; byte k = in_data[8k+7:8k] goes to bank k.
- in_ready  out  1  loader can accept a word this cycle.
- image_ram_addr  out  ADDR_W  bank write address.
- data_image_0..data_image_3  out  8 each  bank 0..3 write data.
- we_image  out  1  write enable, common to all four banks.
- busy  out  1  high in LOAD and DONE.
- done  out  1  one-cycle pulse at end of load.
- drop_err  out  1  sticky flag: a word was presented while not loading.
- words_written  out  ADDR_W+1  count of words written in the current or last load.

Behaviour:
- Reset values (synchronous, highest priority, also mid-load): state=IDLE; all of the following are 0: in_ready, we_image, image_ram_addr, data_image_0..3, busy, done, drop_err, words_written.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - in_ready=0.
  - start=1 with num_words=0 → DONE, with words_written=0.
  - start=1 with num_words>0 → latch target=min(num_words, DEPTH); clear words_written and drop_err; → LOAD.
  - in_valid=1 with no accepted start that cycle → set drop_err. The word is discarded.
- LOAD:
  - in_ready=1 combinationally from state (no dependency on in_valid).
  - Handshake: a transfer occurs when in_valid & in_ready.
  - On a transfer in cycle N, in cycle N+1 (registered, latency 1):
    - we_image=1.
    - image_ram_addr = words_written value before the increment.
    - data_image_k = byte k.
    - words_written incremented.
  - we_image=0 in any cycle without a preceding transfer; addr and data hold their last values.
  - Back-to-back transfers every cycle give one write per cycle at consecutive addresses 0,1,2,…
  - Transfer that makes words_written reach target → next state DONE; in_ready=0 from the following cycle.
  - start during LOAD is ignored.
  - Address never exceeds target−1, so no wrap occurs. Target clamping guarantees addr ≤ DEPTH−1.
- DONE:
  - done=1 for exactly one cycle; in_ready=0.
  - we_image carries the final write, asserted in the first DONE cycle.
  - Then → IDLE.
  - in_valid in DONE sets drop_err.
  - start in DONE is ignored.
- busy = (state != IDLE).
- words_written holds its final value in IDLE until the next accepted start.
- Simultaneous start and in_valid in IDLE: start is accepted, the word is dropped, and drop_err is cleared (clear wins) and not set that cycle.

Test Plan:
- Reset, start with num_words=4, words 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D presented back-to-back → four writes at addr 0..3. Addr 0 carries d0=01, d1=02, d2=03, d3=04. done pulses in the cycle after the last write's transfer. words_written=4.
- num_words=3 with in_valid toggling 1,0,1,0,1 → we_image high only in the cycles after transfers, at addr 0,1,2. No gaps in addressing.
- num_words=0 → done pulses within 2 cycles; no we_image; words_written=0.
- num_words=20000 (above DEPTH) → loader accepts exactly 16384 words. Last write is at addr 16383; in_ready drops afterwards.
- in_valid=1 in IDLE → drop_err=1, no write. A subsequent start clears drop_err to 0.
- reset asserted after 2 of 5 words → next cycle state IDLE with in_ready=0, we_image=0, words_written=0. A new start with num_words=2 writes addr 0,1 normally.
